// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Control unit for the Y86 five-stage pipeline. Generates the
//               per-cycle stall/bubble commands for the F/D/E/M/W pipeline
//               registers, runs an IDLE/RUN/HALTED state machine that latches
//               the architectural status when a faulting or halting
//               instruction reaches writeback, and keeps saturating RUN-cycle
//               and retired-instruction counters.
// Ports       : clk, rst (async, active-low)
//               start, clear             - run control levels
//               D_icode, d_srcA, d_srcB  - decode-stage hazard sources
//               E_icode, E_dstM, e_Cnd   - execute-stage hazard sources
//               M_icode, m_stat          - memory-stage icode/status
//               W_icode, W_stat          - writeback-stage icode/status
//               F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
//               set_cc                   - pipeline control outputs
//               running, cpu_stat        - run state and latched status
//               cycle_cnt, instr_cnt     - debug counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter logic [7:0] RNONE = 8'h0F,
    parameter int         CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [7:0]       D_icode,
    input  logic [7:0]       d_srcA,
    input  logic [7:0]       d_srcB,
    input  logic [7:0]       E_icode,
    input  logic [7:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [7:0]       M_icode,
    input  logic [7:0]       m_stat,
    input  logic [7:0]       W_icode,
    input  logic [7:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             running,
    output logic [7:0]       cpu_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    // Instruction codes
    localparam logic [7:0] c_I_NOP    = 8'h01;
    localparam logic [7:0] c_I_OPL    = 8'h06;
    localparam logic [7:0] c_I_MRMOVL = 8'h05;
    localparam logic [7:0] c_I_JXX    = 8'h07;
    localparam logic [7:0] c_I_RET    = 8'h09;
    localparam logic [7:0] c_I_POPL   = 8'h0B;

    // Status codes
    localparam logic [7:0] c_S_AOK = 8'h01;
    localparam logic [7:0] c_S_HLT = 8'h02;
    localparam logic [7:0] c_S_ADR = 8'h03;
    localparam logic [7:0] c_S_INS = 8'h04;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_cpu_stat;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    logic w_loaduse;
    logic w_retp;
    logic w_mispred;
    logic w_exc_w;
    logic w_exc_mw;
    logic w_retire;

    function automatic logic f_exc(input logic [7:0] s);
        return (s == c_S_HLT) || (s == c_S_ADR) || (s == c_S_INS);
    endfunction

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_loaduse = ((E_icode == c_I_MRMOVL) || (E_icode == c_I_POPL)) &&
                       (E_dstM != RNONE) &&
                       ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign w_retp    = (D_icode == c_I_RET) || (E_icode == c_I_RET) ||
                       (M_icode == c_I_RET);
    assign w_mispred = (E_icode == c_I_JXX) && !e_Cnd;
    assign w_exc_w   = f_exc(W_stat);
    assign w_exc_mw  = f_exc(m_stat) || w_exc_w;
    // A HALT carries HLT status, so it never satisfies the AOK term here.
    assign w_retire  = (W_stat == c_S_AOK) && (W_icode != c_I_NOP);

    // ------------------------------------------------------------------
    // State register, status latch and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cpu_stat  <= c_S_AOK;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (clear) begin
                r_cpu_stat  <= c_S_AOK;
                r_cycle_cnt <= '0;
                r_instr_cnt <= '0;
            end else if (r_state == S_RUN) begin
                if (w_exc_w) begin
                    r_cpu_stat <= W_stat;
                end
                if (!(&r_cycle_cnt)) begin
                    r_cycle_cnt <= r_cycle_cnt + c_CNT_ONE;
                end
                if (w_retire && !(&r_instr_cnt)) begin
                    r_instr_cnt <= r_instr_cnt + c_CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and pipeline control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        // Frozen pipeline by default; only RUN lets instructions advance.
        F_stall     = 1'b1;
        D_stall     = 1'b0;
        D_bubble    = 1'b1;
        E_bubble    = 1'b1;
        M_bubble    = 1'b1;
        W_stall     = 1'b1;
        set_cc      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                F_stall  = w_loaduse || w_retp;
                D_stall  = w_loaduse;
                // A load/use stall outranks the RET bubble: the decode
                // register must hold the consumer, not be flushed.
                D_bubble = w_mispred || (w_retp && !w_loaduse);
                E_bubble = w_mispred || w_loaduse;
                M_bubble = w_exc_mw;
                W_stall  = w_exc_w;
                set_cc   = (E_icode == c_I_OPL) && !w_exc_mw;
                if (w_exc_w) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // clear outranks both start and the halt transition.
        if (clear) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign running   = (r_state == S_RUN);
    assign cpu_stat  = r_cpu_stat;
    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl. Directed scenarios followed
//               by randomized traffic, compared each cycle against a
//               behavioural model of the run/halt rules, hazard rules and
//               saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int         TB_CNT_W = 6;
    localparam logic [7:0] TB_RNONE = 8'h0F;
    localparam int         CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk;
    logic                rst;
    logic                start;
    logic                clear;
    logic [7:0]          D_icode;
    logic [7:0]          d_srcA;
    logic [7:0]          d_srcB;
    logic [7:0]          E_icode;
    logic [7:0]          E_dstM;
    logic                e_Cnd;
    logic [7:0]          M_icode;
    logic [7:0]          m_stat;
    logic [7:0]          W_icode;
    logic [7:0]          W_stat;
    logic                F_stall;
    logic                D_stall;
    logic                D_bubble;
    logic                E_bubble;
    logic                M_bubble;
    logic                W_stall;
    logic                set_cc;
    logic                running;
    logic [7:0]          cpu_stat;
    logic [TB_CNT_W-1:0] cycle_cnt;
    logic [TB_CNT_W-1:0] instr_cnt;

    pipe_ctrl #(
        .RNONE (TB_RNONE),
        .CNT_W (TB_CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear     (clear),
        .D_icode   (D_icode),
        .d_srcA    (d_srcA),
        .d_srcB    (d_srcB),
        .E_icode   (E_icode),
        .E_dstM    (E_dstM),
        .e_Cnd     (e_Cnd),
        .M_icode   (M_icode),
        .m_stat    (m_stat),
        .W_icode   (W_icode),
        .W_stat    (W_stat),
        .F_stall   (F_stall),
        .D_stall   (D_stall),
        .D_bubble  (D_bubble),
        .E_bubble  (E_bubble),
        .M_bubble  (M_bubble),
        .W_stall   (W_stall),
        .set_cc    (set_cc),
        .running   (running),
        .cpu_stat  (cpu_stat),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: mode 0 = idle, 1 = run, 2 = halted
    // ------------------------------------------------------------------
    int         m_mode;
    logic [7:0] m_stat_q;
    int         m_cyc;
    int         m_ins;

    function automatic bit is_exc(input logic [7:0] s);
        return (s >= 8'd2) && (s <= 8'd4);
    endfunction

    task automatic model_reset();
        m_mode   = 0;
        m_stat_q = 8'h01;
        m_cyc    = 0;
        m_ins    = 0;
    endtask

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
    function automatic logic [6:0] exp_ctrl();
        bit lu, rp, mp, emw;
        if (m_mode != 1) return 7'b1011110;
        lu  = ((E_icode == 8'd5) || (E_icode == 8'h0B)) && (E_dstM != TB_RNONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        rp  = (D_icode == 8'd9) || (E_icode == 8'd9) || (M_icode == 8'd9);
        mp  = (E_icode == 8'd7) && !e_Cnd;
        emw = is_exc(m_stat) || is_exc(W_stat);
        return {lu | rp, lu, mp | (rp & !lu), mp | lu, emw, is_exc(W_stat),
                (E_icode == 8'd6) && !emw};
    endfunction

    task automatic model_advance();
        if (!rst || clear) begin
            model_reset();
            return;
        end
        if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_cyc < CNT_MAX) m_cyc++;
            if (W_stat == 8'd1 && W_icode != 8'd1 && m_ins < CNT_MAX) m_ins++;
            if (is_exc(W_stat)) begin
                m_mode   = 2;
                m_stat_q = W_stat;
            end
        end
    endtask

    task automatic compare_all();
        check("ctrl", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}, exp_ctrl());
        check("running", running, (m_mode == 1));
        check("cpu_stat", cpu_stat, m_stat_q);
        check("cycle_cnt", cycle_cnt, m_cyc);
        check("instr_cnt", instr_cnt, m_ins);
    endtask

    // Inputs are applied just after a falling edge; outputs are sampled 1
    // time unit later and the model then steps across the next rising edge.
    task automatic run_cycle();
        #1;
        compare_all();
        model_advance();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        start   = 1'b0;
        clear   = 1'b0;
        D_icode = 8'd1;
        d_srcA  = TB_RNONE;
        d_srcB  = TB_RNONE;
        E_icode = 8'd1;
        E_dstM  = TB_RNONE;
        e_Cnd   = 1'b1;
        M_icode = 8'd1;
        m_stat  = 8'd1;
        W_icode = 8'd1;
        W_stat  = 8'd1;
    endtask

    function automatic logic [7:0] rand_icode();
        logic [7:0] tbl [9];
        tbl = '{8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd9, 8'h0B, 8'd3};
        return tbl[$urandom_range(0, 8)];
    endfunction

    function automatic logic [7:0] rand_reg();
        return ($urandom_range(0, 4) == 0) ? TB_RNONE : 8'($urandom_range(0, 3));
    endfunction

    function automatic logic [7:0] rand_stat(input int exc_odds);
        if ($urandom_range(0, exc_odds - 1) != 0) return 8'd1;
        return 8'($urandom_range(0, 4));
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b0;
        quiet_inputs();
        model_reset();
        @(negedge clk);
        run_cycle();                    // frozen outputs while in reset
        rst = 1'b1;
        run_cycle();                    // idle after release
        run_cycle();

        // Reset then start, NOP traffic
        start = 1'b1;
        run_cycle();
        start = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle();

        // Load/use, then no hazard with RNONE
        E_icode = 8'd5; E_dstM = 8'd3; d_srcB = 8'd3;
        run_cycle();
        E_dstM = TB_RNONE; d_srcB = TB_RNONE;
        run_cycle();
        // Load/use together with RET in M
        E_icode = 8'h0B; E_dstM = 8'd2; d_srcA = 8'd2; M_icode = 8'd9;
        run_cycle();
        quiet_inputs();

        // Mispredict, then RET in decode
        E_icode = 8'd7; e_Cnd = 1'b0;
        run_cycle();
        quiet_inputs();
        D_icode = 8'd9;
        run_cycle();
        quiet_inputs();

        // Some AOK retirements, then halt
        W_icode = 8'd6;
        for (int i = 0; i < 3; i++) run_cycle();
        W_icode = 8'd0; W_stat = 8'd2;
        run_cycle();
        quiet_inputs();
        start = 1'b1;                   // ignored while halted
        run_cycle();
        run_cycle();
        start = 1'b0;

        // Fault and clear
        clear = 1'b1;
        run_cycle();
        clear = 1'b0; start = 1'b1;
        run_cycle();
        start = 1'b0;
        m_stat = 8'd3; E_icode = 8'd6;
        run_cycle();
        m_stat = 8'd1; W_stat = 8'd3;
        run_cycle();
        quiet_inputs();
        run_cycle();
        clear = 1'b1; start = 1'b1;
        run_cycle();
        quiet_inputs();
        run_cycle();

        // Counter saturation
        start = 1'b1;
        run_cycle();
        start = 1'b0;
        W_icode = 8'd6;
        for (int i = 0; i < CNT_MAX + 6; i++) run_cycle();

        // Asynchronous reset between edges while running
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b1;
        quiet_inputs();
        run_cycle();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            start   = ($urandom_range(0, 3) == 0);
            clear   = ($urandom_range(0, 59) == 0);
            D_icode = rand_icode();
            d_srcA  = rand_reg();
            d_srcB  = rand_reg();
            E_icode = rand_icode();
            E_dstM  = rand_reg();
            e_Cnd   = 1'($urandom_range(0, 1));
            M_icode = rand_icode();
            m_stat  = rand_stat(12);
            W_icode = rand_icode();
            W_stat  = rand_stat(30);
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
